key_debouncer: RTL and testbench



---
 rtl/key_debouncer.sv | 152 +++++++++++++++
 tb/tb_key_debouncer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/key_debouncer.sv
// Per-key synchroniser, debouncer and auto-repeat generator for active-low push-buttons.
// Each key yields a clean active-high level plus one-cycle press, release and repeat pulses.
//
// Repeat FSM (one per key)
//   state  | meaning
//   IDLE   | key released, or held but not yet accepted; rcnt parked at 0
//   HOLD   | press accepted, counting REPEAT_DELAY to the first repeat
//   REPEAT | auto-repeating, one pulse every REPEAT_PERIOD cycles
module key_debouncer #(
    parameter int W               = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter bit ENABLE_REPEAT   = 1'b1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] key,
    output logic [W-1:0] pressed,
    output logic [W-1:0] press_pulse,
    output logic [W-1:0] release_pulse,
    output logic [W-1:0] repeat_pulse
);

    localparam int DCW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCW  = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [DCW-1:0] DEB_LAST   = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCW-1:0] DELAY_LAST = RCW'(REPEAT_DELAY - 1);
    localparam logic [RCW-1:0] PER_LAST   = RCW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } rstate_t;

    for (genvar i = 0; i < W; i++) begin : g_key
        logic           sync1;
        logic           sync2;
        logic           s;
        logic           stable;
        logic [DCW-1:0] dcnt;
        logic           pp_r;
        logic           rp_r;
        logic           acc_press;
        logic           acc_release;

        assign s = ~sync2;

        // A level change is accepted on the edge where the counter saturates.
        assign acc_press   = (s != stable) && (dcnt == DEB_LAST) && s;
        assign acc_release = (s != stable) && (dcnt == DEB_LAST) && !s;

        always_ff @(posedge clock) begin
            if (reset) begin
                sync1  <= 1'b1;
                sync2  <= 1'b1;
                stable <= 1'b0;
                dcnt   <= '0;
                pp_r   <= 1'b0;
                rp_r   <= 1'b0;
            end else begin
                sync1 <= key[i];
                sync2 <= sync1;
                pp_r  <= acc_press;
                rp_r  <= acc_release;
                if (s == stable) begin
                    dcnt <= '0;
                end else if (dcnt == DEB_LAST) begin
                    stable <= s;
                    dcnt   <= '0;
                end else begin
                    dcnt <= dcnt + 1'b1;
                end
            end
        end

        assign pressed[i]       = stable;
        assign press_pulse[i]   = pp_r;
        assign release_pulse[i] = rp_r;

        if (ENABLE_REPEAT) begin : g_rpt
            rstate_t        state;
            rstate_t        state_n;
            logic [RCW-1:0] rcnt;
            logic [RCW-1:0] rcnt_n;
            logic           rep_n;
            logic           rep_r;

            always_ff @(posedge clock) begin
                if (reset) begin
                    state <= IDLE;
                    rcnt  <= '0;
                    rep_r <= 1'b0;
                end else begin
                    state <= state_n;
                    rcnt  <= rcnt_n;
                    rep_r <= rep_n;
                end
            end

            // Driven by the accept events rather than the registered pulses so the
            // first repeat lands exactly REPEAT_DELAY cycles after press_pulse.
            always_comb begin
                state_n = state;
                rcnt_n  = rcnt;
                rep_n   = 1'b0;
                if (acc_release) begin
                    state_n = IDLE;
                    rcnt_n  = '0;
                end else begin
                    case (state)
                        IDLE: begin
                            if (acc_press) begin
                                state_n = HOLD;
                                rcnt_n  = '0;
                            end
                        end
                        HOLD: begin
                            if (rcnt == DELAY_LAST) begin
                                rep_n   = 1'b1;
                                rcnt_n  = '0;
                                state_n = REPEAT;
                            end else begin
                                rcnt_n = rcnt + 1'b1;
                            end
                        end
                        REPEAT: begin
                            if (rcnt == PER_LAST) begin
                                rep_n  = 1'b1;
                                rcnt_n = '0;
                            end else begin
                                rcnt_n = rcnt + 1'b1;
                            end
                        end
                        default: begin
                            state_n = IDLE;
                            rcnt_n  = '0;
                        end
                    endcase
                end
            end

            assign repeat_pulse[i] = rep_r;
        end else begin : g_norpt
            assign repeat_pulse[i] = 1'b0;
        end
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Scoreboard bench for key_debouncer: stimulus queues expected pulse events,
// a monitor pops and compares them whenever the DUT emits a pulse or one is due.
module tb_key_debouncer;

    localparam int W = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] key   = 4'hF;
    logic [W-1:0] pressed;
    logic [W-1:0] press_pulse;
    logic [W-1:0] release_pulse;
    logic [W-1:0] repeat_pulse;

    key_debouncer #(
        .W              (W),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3),
        .ENABLE_REPEAT  (1'b1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .key          (key),
        .pressed      (pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .repeat_pulse (repeat_pulse)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int           c;
        logic [W-1:0] pp;
        logic [W-1:0] rp;
        logic [W-1:0] rep;
    } ev_t;

    ev_t q[$];
    int  checks   = 0;
    int  failures = 0;

    task automatic expect_ev(input int c, input logic [W-1:0] pp,
                             input logic [W-1:0] rp, input logic [W-1:0] rep);
        ev_t e;
        e.c   = c;
        e.pp  = pp;
        e.rp  = rp;
        e.rep = rep;
        q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    // Monitor
    initial begin
        ev_t e;
        forever begin
            @(negedge clock);
            if ((|press_pulse) || (|release_pulse) || (|repeat_pulse) ||
                (q.size() > 0 && q[0].c == cyc)) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse: got pp=%b rp=%b rep=%b at cycle %0d, expected none",
                             press_pulse, release_pulse, repeat_pulse, cyc);
                end else begin
                    e = q.pop_front();
                    if (e.c != cyc || e.pp !== press_pulse || e.rp !== release_pulse ||
                        e.rep !== repeat_pulse) begin
                        failures++;
                        $display("FAIL event: got cycle %0d pp=%b rp=%b rep=%b, expected cycle %0d pp=%b rp=%b rep=%b",
                                 cyc, press_pulse, release_pulse, repeat_pulse,
                                 e.c, e.pp, e.rp, e.rep);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int p;

        repeat (3) @(negedge clock);
        check("reset_outputs", {pressed, press_pulse, release_pulse, repeat_pulse}, 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // key[0] press, hold for 30 cycles of repeats, then release
        t = cyc;
        p = t + 6;
        expect_ev(p, 4'b0001, 4'b0000, 4'b0000);
        for (int k = 10; k <= 28; k += 3) expect_ev(p + k, 4'b0000, 4'b0000, 4'b0001);
        expect_ev(p + 30, 4'b0000, 4'b0001, 4'b0000);
        key[0] = 1'b0;
        wait_cyc(p - 1);
        check("s1_pressed_before_accept", pressed, 32'h0);
        wait_cyc(p);
        check("s1_pressed_after_accept", pressed, 32'h1);
        wait_cyc(p + 24);
        key[0] = 1'b1;
        wait_cyc(p + 31);
        check("s1_pressed_after_release", pressed, 32'h0);
        wait_cyc(p + 40);

        // key[1] bouncing: toggles every 2 cycles, then settles low
        t = cyc;
        expect_ev(t + 18, 4'b0010, 4'b0000, 4'b0000);
        expect_ev(t + 25, 4'b0000, 4'b0010, 4'b0000);
        key[1] = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            wait_cyc(t + 2 * i);
            key[1] = (i % 2 == 1);
        end
        wait_cyc(t + 17);
        check("s2_no_press_during_bounce", pressed, 32'h0);
        wait_cyc(t + 19);
        key[1] = 1'b1;
        wait_cyc(t + 35);

        // release accepted exactly when the second repeat would fire
        t = cyc;
        p = t + 6;
        expect_ev(p, 4'b0001, 4'b0000, 4'b0000);
        expect_ev(p + 10, 4'b0000, 4'b0000, 4'b0001);
        expect_ev(p + 13, 4'b0000, 4'b0001, 4'b0000);
        key[0] = 1'b0;
        wait_cyc(p + 7);
        key[0] = 1'b1;
        wait_cyc(p + 30);

        // key[2] and key[3] together
        t = cyc;
        p = t + 6;
        expect_ev(p, 4'b1100, 4'b0000, 4'b0000);
        for (int k = 10; k <= 19; k += 3) expect_ev(p + k, 4'b0000, 4'b0000, 4'b1100);
        expect_ev(p + 20, 4'b0000, 4'b1100, 4'b0000);
        key[3:2] = 2'b00;
        wait_cyc(p);
        check("s5_pressed_pair", pressed, 32'hC);
        wait_cyc(p + 14);
        key[3:2] = 2'b11;
        wait_cyc(p + 30);

        // reset while key[0] is held and repeating
        t = cyc;
        p = t + 6;
        expect_ev(p, 4'b0001, 4'b0000, 4'b0000);
        expect_ev(p + 10, 4'b0000, 4'b0000, 4'b0001);
        expect_ev(p + 13, 4'b0000, 4'b0000, 4'b0001);
        expect_ev(p + 21, 4'b0001, 4'b0000, 4'b0000);
        expect_ev(p + 28, 4'b0000, 4'b0001, 4'b0000);
        key[0] = 1'b0;
        wait_cyc(p + 14);
        reset = 1'b1;
        wait_cyc(p + 15);
        reset = 1'b0;
        check("s6_reset_clears", {pressed, press_pulse, release_pulse, repeat_pulse}, 32'h0);
        wait_cyc(p + 20);
        check("s6_pressed_before_reaccept", pressed, 32'h0);
        wait_cyc(p + 22);
        key[0] = 1'b1;
        wait_cyc(p + 40);

        check("queue_drained", q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
